i2c_input_filter: RTL and testbench

I2C_INPUT_FILTER -- requirements
Module: i2c_input_filter

---
 rtl/i2c_input_filter.sv | 124 ++++++++++++
 tb/tb_i2c_input_filter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_input_filter.sv
// ============================================================================
// Module   : i2c_input_filter
// Purpose  : Pad-side SCL/SDA synchronizer, spike filter, START/STOP detect,
//            bus-busy tracking and SCL-low timeout for an I2C controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_input_filter #(
  parameter int FILT_W = 4,
  parameter int TMO_W  = 16
) (
  input  logic              ip_clk,
  input  logic              rst_an,
  input  logic              rawScl,
  input  logic              rawSda,
  input  logic [FILT_W-1:0] filtLen,
  input  logic [TMO_W-1:0]  tmoVal,
  input  logic              clearStuck,
  output logic              sclFilt,
  output logic              sdaFilt,
  output logic              startDet,
  output logic              stopDet,
  output logic              busBusy,
  output logic              sclStuck
);

  localparam logic [FILT_W-1:0] c_filtOne = {{(FILT_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  c_tmoOne  = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {rawSda, rawScl};

  // Index 0 is SCL, index 1 is SDA; both lines use the identical filter.
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic              r_s1;
    logic              r_s2;
    logic              r_out;
    logic [FILT_W-1:0] r_cnt;

    always_ff @(posedge ip_clk or negedge rst_an) begin
      if (!rst_an) begin
        r_s1  <= 1'b1;
        r_s2  <= 1'b1;
        r_out <= 1'b1;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_raw[gi];
        r_s2 <= r_s1;
        if (r_s2 == r_out) begin
          r_cnt <= '0;
        end else if (r_cnt >= filtLen) begin
          r_out <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_filtOne;
        end
      end
    end

    assign w_filt[gi] = r_out;
  end

  assign sclFilt = w_filt[0];
  assign sdaFilt = w_filt[1];

  logic             r_sclPrev;
  logic             r_sdaPrev;
  logic [TMO_W-1:0] r_tcnt;
  logic             w_start;
  logic             w_stop;
  logic             w_tmoEn;
  logic             w_stuckSet;

  // SCL must be high on both sides of the SDA edge, so simultaneous edges never qualify.
  assign w_start    = r_sclPrev & sclFilt & r_sdaPrev & ~sdaFilt;
  assign w_stop     = r_sclPrev & sclFilt & ~r_sdaPrev & sdaFilt;
  assign w_tmoEn    = (tmoVal != '0);
  assign w_stuckSet = w_tmoEn & ~sclFilt & (r_tcnt == (tmoVal - c_tmoOne));

  always_ff @(posedge ip_clk or negedge rst_an) begin
    if (!rst_an) begin
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
      startDet  <= 1'b0;
      stopDet   <= 1'b0;
      busBusy   <= 1'b0;
    end else begin
      r_sclPrev <= sclFilt;
      r_sdaPrev <= sdaFilt;
      startDet  <= w_start;
      stopDet   <= w_stop;
      if (w_stuckSet || w_stop) begin
        busBusy <= 1'b0;
      end else if (w_start) begin
        busBusy <= 1'b1;
      end
    end
  end

  // Saturating counter: once past tmoVal-1 it cannot match again this low period.
  always_ff @(posedge ip_clk or negedge rst_an) begin
    if (!rst_an) begin
      r_tcnt   <= '0;
      sclStuck <= 1'b0;
    end else begin
      if (sclFilt || !w_tmoEn) begin
        r_tcnt <= '0;
      end else if (r_tcnt != '1) begin
        r_tcnt <= r_tcnt + c_tmoOne;
      end
      if (w_stuckSet) begin
        sclStuck <= 1'b1;
      end else if (clearStuck) begin
        sclStuck <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_input_filter.sv
// ============================================================================
// Module   : tb_i2c_input_filter
// Purpose  : Directed scoreboard bench for i2c_input_filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_input_filter;

  localparam int FILT_W = 4;
  localparam int TMO_W  = 16;

  localparam int B_SCL   = 5;
  localparam int B_SDA   = 4;
  localparam int B_START = 3;
  localparam int B_STOP  = 2;
  localparam int B_BUSY  = 1;
  localparam int B_STUCK = 0;
  localparam logic [5:0] c_idle = 6'b110000;

  logic              ip_clk;
  logic              rst_an;
  logic              rawScl;
  logic              rawSda;
  logic [FILT_W-1:0] filtLen;
  logic [TMO_W-1:0]  tmoVal;
  logic              clearStuck;
  logic              sclFilt;
  logic              sdaFilt;
  logic              startDet;
  logic              stopDet;
  logic              busBusy;
  logic              sclStuck;

  i2c_input_filter #(.FILT_W(FILT_W), .TMO_W(TMO_W)) dut (
    .ip_clk    (ip_clk),
    .rst_an    (rst_an),
    .rawScl    (rawScl),
    .rawSda    (rawSda),
    .filtLen   (filtLen),
    .tmoVal    (tmoVal),
    .clearStuck(clearStuck),
    .sclFilt   (sclFilt),
    .sdaFilt   (sdaFilt),
    .startDet  (startDet),
    .stopDet   (stopDet),
    .busBusy   (busBusy),
    .sclStuck  (sclStuck)
  );

  initial ip_clk = 1'b0;
  always #5 ip_clk = ~ip_clk;

  int edgeCnt = 0;
  always @(posedge ip_clk) edgeCnt <= edgeCnt + 1;

  typedef struct {
    int         cyc;
    logic [5:0] mask;
    logic [5:0] val;
    string      name;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nPass   = 0;

  task automatic expectBit(input int c, input int b, input logic v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.mask = '0;
    e.mask[b] = 1'b1;
    e.val  = '0;
    e.val[b] = v;
    e.name = nm;
    sbQ.push_back(e);
  endtask

  task automatic expectAll(input int c, input logic [5:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.mask = '1;
    e.val  = v;
    e.name = nm;
    sbQ.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ip_clk);
    #1;
  endtask

  // Monitor: every cycle the outputs are presented; pop entries due now.
  always @(negedge ip_clk) begin
    logic [5:0] act;
    act = {sclFilt, sdaFilt, startDet, stopDet, busBusy, sclStuck};
    for (int i = 0; i < sbQ.size(); ) begin
      if (sbQ[i].cyc <= edgeCnt) begin
        nChecks++;
        if (sbQ[i].cyc < edgeCnt) begin
          $display("FAIL %s: check missed at cycle %0d (now %0d)", sbQ[i].name, sbQ[i].cyc, edgeCnt);
        end else if (((act ^ sbQ[i].val) & sbQ[i].mask) != '0) begin
          $display("FAIL %s: cycle %0d got %b expected %b (mask %b)",
                   sbQ[i].name, edgeCnt, act & sbQ[i].mask, sbQ[i].val, sbQ[i].mask);
        end else begin
          nPass++;
        end
        sbQ.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    int m, m2, m3;
    rst_an     = 1'b0;
    rawScl     = 1'b1;
    rawSda     = 1'b1;
    filtLen    = '0;
    tmoVal     = '0;
    clearStuck = 1'b0;
    expectAll(2, c_idle, "reset_state");
    tick(3);
    rst_an = 1'b1;
    tick(2);

    // START then STOP with no filtering
    m = edgeCnt;
    rawSda = 1'b0;
    expectBit(m + 2, B_SDA,   1'b1, "f0_sda_before");
    expectBit(m + 3, B_SDA,   1'b0, "f0_sda_fall");
    expectBit(m + 3, B_START, 1'b0, "f0_start_early");
    expectBit(m + 4, B_START, 1'b1, "f0_start_pulse");
    expectBit(m + 4, B_BUSY,  1'b1, "f0_busy_set");
    expectBit(m + 5, B_START, 1'b0, "f0_start_one_cycle");
    expectBit(m + 5, B_BUSY,  1'b1, "f0_busy_hold");
    tick(6);
    m2 = edgeCnt;
    rawSda = 1'b1;
    expectBit(m2 + 3, B_SDA,  1'b1, "f0_sda_rise");
    expectBit(m2 + 3, B_STOP, 1'b0, "f0_stop_early");
    expectBit(m2 + 4, B_STOP, 1'b1, "f0_stop_pulse");
    expectBit(m2 + 4, B_BUSY, 1'b0, "f0_busy_clear");
    expectBit(m2 + 5, B_STOP, 1'b0, "f0_stop_one_cycle");
    tick(8);

    // filtLen=2: 2-cycle glitch rejected, 3-cycle pulse passes
    filtLen = 4'd2;
    tick(2);
    m = edgeCnt;
    rawSda = 1'b0;
    expectBit(m + 3, B_SDA,   1'b1, "glitch2_sda_c3");
    expectBit(m + 5, B_SDA,   1'b1, "glitch2_sda_c5");
    expectBit(m + 6, B_START, 1'b0, "glitch2_no_start");
    expectBit(m + 7, B_SDA,   1'b1, "glitch2_sda_c7");
    tick(2);
    rawSda = 1'b1;
    tick(10);
    m = edgeCnt;
    rawSda = 1'b0;
    expectBit(m + 4, B_SDA,   1'b1, "pulse3_sda_c4");
    expectBit(m + 5, B_SDA,   1'b0, "pulse3_sda_c5");
    expectBit(m + 6, B_START, 1'b1, "pulse3_start");
    expectBit(m + 6, B_BUSY,  1'b1, "pulse3_busy");
    expectBit(m + 7, B_SDA,   1'b0, "pulse3_sda_c7");
    expectBit(m + 8, B_SDA,   1'b1, "pulse3_sda_c8");
    expectBit(m + 9, B_STOP,  1'b1, "pulse3_stop");
    expectBit(m + 9, B_BUSY,  1'b0, "pulse3_busy_clear");
    tick(3);
    rawSda = 1'b1;
    tick(10);

    // filtLen lowered mid-count takes effect on the next compare
    filtLen = 4'd6;
    tick(2);
    m = edgeCnt;
    rawSda = 1'b0;
    expectBit(m + 4, B_SDA,   1'b1, "midlen_sda_c4");
    expectBit(m + 5, B_SDA,   1'b0, "midlen_sda_c5");
    expectBit(m + 6, B_START, 1'b1, "midlen_start");
    tick(4);
    filtLen = 4'd1;
    tick(4);
    filtLen = 4'd0;
    tick(1);
    m2 = edgeCnt;
    rawSda = 1'b1;
    expectBit(m2 + 3, B_SDA,  1'b1, "midlen_sda_rise");
    expectBit(m2 + 4, B_STOP, 1'b1, "midlen_stop");
    expectBit(m2 + 4, B_BUSY, 1'b0, "midlen_busy_clear");
    tick(8);

    // SCL and SDA fall together, then rise together: no START/STOP
    m = edgeCnt;
    rawScl = 1'b0;
    rawSda = 1'b0;
    expectBit(m + 3, B_SCL,   1'b0, "simul_scl_low");
    expectBit(m + 3, B_SDA,   1'b0, "simul_sda_low");
    expectBit(m + 4, B_START, 1'b0, "simul_no_start");
    expectBit(m + 5, B_BUSY,  1'b0, "simul_busy_idle");
    tick(6);
    m2 = edgeCnt;
    rawScl = 1'b1;
    rawSda = 1'b1;
    expectBit(m2 + 4, B_STOP, 1'b0, "simul_no_stop");
    tick(8);

    // SCL timeout while bus busy
    tmoVal = 16'd10;
    m = edgeCnt;
    rawSda = 1'b0;
    expectBit(m + 4, B_BUSY, 1'b1, "tmo_busy_set");
    tick(6);
    m2 = edgeCnt;
    rawScl = 1'b0;
    expectBit(m2 + 3,  B_SCL,   1'b0, "tmo_scl_low");
    expectBit(m2 + 12, B_STUCK, 1'b0, "tmo_stuck_not_yet");
    expectBit(m2 + 12, B_BUSY,  1'b1, "tmo_busy_before");
    expectBit(m2 + 13, B_STUCK, 1'b1, "tmo_stuck_set");
    expectBit(m2 + 13, B_BUSY,  1'b0, "tmo_busy_cleared");
    tick(15);
    m3 = edgeCnt;
    clearStuck = 1'b1;
    expectBit(m3,     B_STUCK, 1'b1, "tmo_stuck_sticky");
    expectBit(m3 + 1, B_STUCK, 1'b0, "tmo_stuck_cleared");
    expectBit(m3 + 6, B_STUCK, 1'b0, "tmo_no_repulse");
    tick(1);
    clearStuck = 1'b0;
    tick(6);
    rawScl = 1'b1;
    tick(5);
    rawSda = 1'b1;
    tick(6);
    tmoVal = '0;

    // Reset mid-transfer with a filter count pending
    filtLen = 4'd4;
    tick(2);
    m = edgeCnt;
    rawSda = 1'b0;
    expectBit(m + 6, B_SDA,   1'b1, "rst_pre_sda_c6");
    expectBit(m + 7, B_SDA,   1'b0, "rst_pre_sda_fall");
    expectBit(m + 8, B_START, 1'b1, "rst_pre_start");
    expectBit(m + 8, B_BUSY,  1'b1, "rst_pre_busy");
    tick(10);
    m2 = edgeCnt;
    rawScl = 1'b0;
    expectBit(m2 + 3, B_BUSY, 1'b1, "rst_pending_busy");
    expectBit(m2 + 3, B_SCL,  1'b1, "rst_pending_scl");
    expectAll(m2 + 4, c_idle, "rst_async_clear");
    tick(4);
    rst_an = 1'b0;
    rawScl = 1'b1;
    rawSda = 1'b1;
    tick(2);
    m3 = edgeCnt;
    rst_an = 1'b1;
    expectAll(m3 + 1, c_idle, "rst_release_c1");
    expectAll(m3 + 4, c_idle, "rst_release_c4");
    expectAll(m3 + 7, c_idle, "rst_release_c7");
    tick(10);

    for (int k = 0; k < 50 && sbQ.size() > 0; k++) tick(1);
    while (sbQ.size() > 0) begin
      nChecks++;
      $display("FAIL %s: never checked (due cycle %0d)", sbQ[0].name, sbQ[0].cyc);
      void'(sbQ.pop_front());
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
